seven_seg_scan: RTL

- Parametrised time-multiplexed 7-segment driver for NDIG hex digits with per-digit decimal point, per-digit enable and optional leading-zero blanking.
- Sits between datapath registers (counters, ALU results) and the board's shared-cathode display pins.
- Next generation of the fixed 4-digit scanner. It adds a programmable digit count, an exact refresh divider, frame-coherent input capture and blanking.

---
 rtl/seven_seg_scan.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed 7-segment driver for NDIG hex digits.
// Ports: clk/rst (sync, active-high); num/dp_in/digit_en/blank_lz are the display request;
//        sseg/dp/an drive the display pins (all active-low); digit_idx/frame_start report scan position.
module seven_seg_scan #(
  parameter  int NDIG        = 4,
  parameter  int REFRESH_DIV = 50000,
  parameter  int CNT_W       = 16,
  localparam int IW          = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] num,
  input  logic [NDIG-1:0]   dp_in,
  input  logic [NDIG-1:0]   digit_en,
  input  logic              blank_lz,
  output logic [0:6]        sseg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic [IW-1:0]     digit_idx,
  output logic              frame_start
);

  // sseg[0:6] = abcdefg, 0 = segment on
  function automatic logic [0:6] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic              tick;

  // Frame-coherent copies of the display request
  logic [4*NDIG-1:0] sh_num;
  logic [NDIG-1:0]   sh_dp;
  logic [NDIG-1:0]   sh_en;
  logic              sh_blz;
  logic              sh_vld;

  logic [IW-1:0]     nxt;
  logic              frame_begin;
  logic              use_live;
  logic [4*NDIG-1:0] src_num;
  logic [NDIG-1:0]   src_dp;
  logic [NDIG-1:0]   src_en;
  logic              src_blz;
  logic [3:0]        nib;
  logic              upper_zero;
  logic              blanked;
  logic              dp_sel;
  logic              en_sel;
  logic [NDIG-1:0]   an_nxt;
  logic [0:6]        sseg_nxt;
  logic              dp_nxt;

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

  always_comb begin
    nxt         = (digit_idx == IW'(NDIG - 1)) ? '0 : digit_idx + IW'(1);
    frame_begin = (nxt == '0);
    // The digit-0 slot shows the value being captured on this same edge.
    // Before the first capture after reset there is no frame yet, so the
    // leading partial frame shows the live request rather than the zeroed copy.
    use_live    = frame_begin || !sh_vld;
    src_num     = use_live ? num      : sh_num;
    src_dp      = use_live ? dp_in    : sh_dp;
    src_en      = use_live ? digit_en : sh_en;
    src_blz     = use_live ? blank_lz : sh_blz;

    nib        = 4'h0;
    upper_zero = 1'b1;
    an_nxt     = '1;
    dp_sel     = 1'b0;
    en_sel     = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == nxt) begin
        nib       = src_num[4*i +: 4];
        an_nxt[i] = 1'b0;
        dp_sel    = src_dp[i];
        en_sel    = src_en[i];
      end
      // Leading-zero test covers this digit and every digit to its left
      if (i >= int'(nxt) && src_num[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blanked = !frame_begin && src_blz && upper_zero;

    if (!en_sel) begin
      // Disabled digit still occupies its slot so brightness stays uniform
      an_nxt   = '1;
      sseg_nxt = '1;
      dp_nxt   = 1'b1;
    end else begin
      sseg_nxt = blanked ? '1 : decode(nib);
      dp_nxt   = ~dp_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      digit_idx   <= '0;
      sh_num      <= '0;
      sh_dp       <= '0;
      sh_en       <= '0;
      sh_blz      <= 1'b0;
      sh_vld      <= 1'b0;
      an          <= '1;
      sseg        <= '1;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      cnt         <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        digit_idx <= nxt;
        an        <= an_nxt;
        sseg      <= sseg_nxt;
        dp        <= dp_nxt;
        if (frame_begin) begin
          sh_num      <= num;
          sh_dp       <= dp_in;
          sh_en       <= digit_en;
          sh_blz      <= blank_lz;
          sh_vld      <= 1'b1;
          frame_start <= 1'b1;
        end
      end
    end
  end

endmodule
